piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter: the sending end that pairs with the team's serial-to-parallel shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per enabled cycle, MSB-first or LSB-first.
- Signals completion with a one-cycle done pulse.
- Drives the serial data input of the receive shift register, or an external serial line.

---
 rtl/piso_serializer_pkg.sv | 14 +
 rtl/piso_serializer_if.sv | 24 ++
 rtl/piso_serializer.sv | 68 ++++++
 tb/tb_piso_serializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared constants for the serializer and its paired receive shift register.
package piso_serializer_pkg;

  // Shift direction, same encoding as the receive shift register's DIR.
  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  // Two-state transmit FSM.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake plus serial-side signals of the PISO serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             dir;
  logic             shift_en;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output din, din_valid, dir, shift_en,
    input  din_ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  din, din_valid, dir, shift_en,
    output din_ready, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: loads a word on valid/ready, shifts it
// out one bit per shift_en strobe, and pulses done after the last bit.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  state_t             state;
  logic [WIDTH-1:0]   sreg;
  logic [CNT_W-1:0]   cnt;
  logic               dir_q;
  logic               done_q;

  // All outputs are taken from flops; the shift register is zero in IDLE,
  // so dout is naturally 0 there, but the state gate keeps that explicit.
  assign bus.din_ready  = (state == ST_IDLE);
  assign bus.busy       = (state == ST_SHIFT);
  assign bus.dout_valid = (state == ST_SHIFT);
  assign bus.done       = done_q;
  assign bus.dout       = (state == ST_SHIFT) &&
                          ((dir_q == DIR_MSB_FIRST) ? sreg[WIDTH-1] : sreg[0]);

  // FSM, shift register and bit counter; done is a one-cycle registered pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sreg   <= '0;
      cnt    <= '0;
      dir_q  <= DIR_LSB_FIRST;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.din_valid) begin
            sreg  <= bus.din;
            dir_q <= bus.dir;
            cnt   <= CNT_W'(WIDTH);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.shift_en) begin
            if (cnt == CNT_W'(1)) begin
              // Last bit consumed: clear so dout reads 0 in IDLE.
              sreg   <= '0;
              cnt    <= '0;
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              sreg <= (dir_q == DIR_MSB_FIRST) ? {sreg[WIDTH-2:0], 1'b0}
                                               : {1'b0, sreg[WIDTH-1:1]};
              cnt  <= cnt - CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: directed 8-bit scenarios plus a 32-bit randomized
// loopback through a behavioural receive shift register.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8))  a ();
  piso_serializer_if #(.WIDTH(32)) b ();

  piso_serializer #(.WIDTH(8))  dut_a (.clk(clk), .rst(rst), .bus(a));
  piso_serializer #(.WIDTH(32)) dut_b (.clk(clk), .rst(rst), .bus(b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word in IDLE; it loads at the next edge.
  task automatic a_load(input logic [7:0] w, input logic d);
    a.din = w; a.dir = d; a.din_valid = 1'b1; a.shift_en = 1'b1;
    @(negedge clk);
    chk("load_ready", a.din_ready, 1);
    tick();
    a.din_valid = 1'b0;
  endtask

  // Expect nbits of w on dout; each bit held p cycles with the strobe on the last.
  task automatic a_stream(input logic [7:0] w, input logic d, input int nbits,
                          input int p, input bit noise, input bit tog);
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < p; j++) begin
        a.shift_en = (j == p - 1);
        if (noise) begin a.din_valid = 1'($urandom_range(0, 1)); a.din = 8'($urandom); end
        if (tog) a.dir = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("dout", a.dout, d ? 32'((w >> (7 - i)) & 1) : 32'((w >> i) & 1));
        chk("dout_valid", a.dout_valid, 1);
        chk("busy", a.busy, 1);
        chk("ready_shift", a.din_ready, 0);
        chk("done_early", a.done, 0);
        tick();
      end
    end
    a.din_valid = 1'b0;
  endtask

  // The done cycle; optionally presents the next word in it.
  task automatic a_finish(input bit nv, input logic [7:0] nw, input logic nd);
    a.din_valid = nv; a.din = nw; a.dir = nd; a.shift_en = 1'b1;
    @(negedge clk);
    chk("done", a.done, 1);
    chk("done_ready", a.din_ready, 1);
    chk("done_dvld", a.dout_valid, 0);
    chk("done_dout", a.dout, 0);
    tick();
    a.din_valid = 1'b0;
    if (!nv) begin
      @(negedge clk);
      chk("done_pulse", a.done, 0);
      chk("idle_busy", a.busy, 0);
      tick();
    end
  endtask

  logic [31:0] cur, pend, rx;
  logic        cd, pd;
  int          n, guard;

  initial begin
    a.din = '0; a.din_valid = 1'b1; a.dir = 1'b0; a.shift_en = 1'b0;
    b.din = '0; b.din_valid = 1'b0; b.dir = 1'b0; b.shift_en = 1'b0;

    // 1. reset with din_valid asserted
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("rst_ready", a.din_ready, 1);
      chk("rst_dout", a.dout, 0);
      chk("rst_dvld", a.dout_valid, 0);
      chk("rst_busy", a.busy, 0);
      chk("rst_done", a.done, 0);
    end
    tick();
    rst = 1'b0; a.din_valid = 1'b0;
    tick();

    // 2. MSB-first 0xC1
    a_load(8'hC1, 1'b1);
    a_stream(8'hC1, 1'b1, 8, 1, 1'b0, 1'b0);
    a_finish(1'b0, 8'h00, 1'b0);

    // 3. LSB-first 0xC1, dir toggling mid-word
    a_load(8'hC1, 1'b0);
    a_stream(8'hC1, 1'b0, 8, 1, 1'b0, 1'b1);
    a_finish(1'b0, 8'h00, 1'b0);

    // 4. throttled 0x5A MSB-first with din_valid noise
    a_load(8'h5A, 1'b1);
    a_stream(8'h5A, 1'b1, 8, 3, 1'b1, 1'b0);
    a_finish(1'b0, 8'h00, 1'b0);

    // 5a. abort after 3 bits of 0xFF
    a_load(8'hFF, 1'b1);
    a_stream(8'hFF, 1'b1, 3, 1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_dout", a.dout, 0);
    chk("abort_dvld", a.dout_valid, 0);
    chk("abort_busy", a.busy, 0);
    chk("abort_done", a.done, 0);
    tick();
    @(negedge clk);
    chk("abort_nodone", a.done, 0);
    tick();

    // 5b. back-to-back: 0x81 then 0x7E loaded in the done cycle
    a_load(8'h81, 1'b1);
    a_stream(8'h81, 1'b1, 8, 1, 1'b0, 1'b0);
    a_finish(1'b1, 8'h7E, 1'b0);
    a_stream(8'h7E, 1'b0, 8, 1, 1'b0, 1'b0);
    a_finish(1'b0, 8'h00, 1'b0);

    // 6. 32-bit loopback; next word is always pending so it loads in the done cycle
    cur = $urandom; cd = 1'($urandom_range(0, 1));
    b.din = cur; b.dir = cd; b.din_valid = 1'b1; b.shift_en = 1'b1;
    tick();
    pend = $urandom; pd = 1'($urandom_range(0, 1));
    b.din = pend; b.dir = pd;
    rx = '0; n = 0; guard = 0;
    while (n < 1000) begin
      @(negedge clk);
      if (b.done) begin
        chk("loopback", rx, cur);
        n++;
        cur = pend; cd = pd; rx = '0; guard = 0;
        pend = $urandom; pd = 1'($urandom_range(0, 1));
      end else if (b.dout_valid) begin
        rx = cd ? {rx[30:0], b.dout} : {b.dout, rx[31:1]};
      end
      guard++;
      if (guard > 40) begin
        chk("loop_timeout", 32'(guard), 0);
        break;
      end
      tick();
      b.din = pend; b.dir = pd;
    end
    b.din_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
